ldr_writeback_queue: RTL
========================

Name: ldr_writeback_queue

Overview:
- Parametrised successor to the single-bit load write-enable decoder in the writeback stage.
- Decodes load instructions and buffers their writebacks in a DEPTH-entry FIFO.
- Arbitrates a single register-file write port between the ALU writeback path, which always has priority, and queued load results.
- Preserves write-after-write ordering, exposes a hazard probe for the decode stage, and raises a stall when the buffer is full.

Parameters:
DEPTH, 4, number of load entries buffered; power of two, minimum 2
DATA_W, 32, writeback data width
REG_ADDR_W, 4, register-file address width
CNT_W, $clog2(DEPTH+1), width of q_count

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
ld_valid_in  input  1  a load result is presented this cycle
opcode_in  input  7  decoded opcode of the presented instruction
ld_rd_in  input  REG_ADDR_W  load destination register
ld_data_in  input  DATA_W  load data
alu_w_en_in  input  1  ALU writeback request this cycle
alu_rd_in  input  REG_ADDR_W  ALU destination register
alu_data_in  input  DATA_W  ALU result
rf_w_en  output  1  registered register-file write enable
rf_w_addr  output  REG_ADDR_W  registered write address
rf_w_data  output  DATA_W  registered write data
w_en_ldr  output  1  registered; high when the current rf write comes from a load
ld_stall  output  1  combinational; equals q_full
q_full  output  1  combinational; count == DEPTH
q_empty  output  1  combinational; count == 0
q_count  output  CNT_W  registered number of occupied entries, including killed entries
probe_addr  input  REG_ADDR_W  register address queried by decode
probe_hit  output  1  combinational; any live entry has rd == probe_addr

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rf_w_en=0, rf_w_addr=0, rf_w_data=0, w_en_ldr=0, q_count=0. All entry-live bits are cleared and the read/write pointers are set to 0. A reset asserted mid-operation discards all queued loads with no write issued.
- Load decode: is_load = (opcode_in[6:4]==3'b110) || (opcode_in[6:3]==4'b1000).
  - A load is accepted when ld_valid_in && is_load && !q_full.
  - Non-load opcodes are ignored.
  - A load presented while full is dropped; the upstream stage must hold it under ld_stall.
- Per-cycle priority, evaluated at each rising edge:
  1. If alu_w_en_in: write the ALU result to the output registers (rf_w_en=1, w_en_ldr=0). Latency is 1 cycle.
  2. Else if the queue is non-empty: pop the head.
     - If the head is live: rf_w_en=1, w_en_ldr=1, with the head's address and data.
     - If the head is killed: rf_w_en=0, w_en_ldr=0.
  3. Else if a load is accepted (queue empty): bypass the queue and write the load directly to the output registers (rf_w_en=1, w_en_ldr=1). Latency is 1 cycle.
  4. Else: rf_w_en=0, w_en_ldr=0. rf_w_addr and rf_w_data hold their previous values.
- Enqueue: an accepted load not consumed by bypass is written at the write pointer and marked live. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: q_count is unchanged. Full status is taken from the pre-edge count, so a load is not accepted while full, even in a cycle that pops.
- Ordering rules:
  - Loads leave the queue in FIFO order.
  - Bypass is allowed only when the queue is empty.
- WAW kill:
  - When alu_w_en_in is high, every live queued entry with rd == alu_rd_in is marked killed at that edge.
  - If an accepted load in the same cycle has ld_rd_in == alu_rd_in, the load is treated as older and is discarded entirely. It is neither enqueued nor written.
  - A killed entry still occupies its slot until popped.
- probe_hit considers live entries only. It does not consider the output register or the incoming load.

Test Plan:
- Bypass: empty queue, alu_w_en_in=0, load opcode 7'b1100000, rd=3, data=0xDEADBEEF for one cycle -> next cycle rf_w_en=1, w_en_ldr=1, addr=3, data=0xDEADBEEF; q_count stays 0.
- ALU priority and drain: alu_w_en_in=1 for 3 cycles (rd=1, 2, 4) while loads rd=5, 6 are presented in cycles 0 and 1 -> ALU writes in cycles 1-3; q_count peaks at 2; loads rd=5 then rd=6 write in cycles 4 and 5 with w_en_ldr=1.
- Full and stall, DEPTH=4: hold alu_w_en_in=1 and present 5 loads -> after 4 accepts q_full=ld_stall=1 and the fifth is not enqueued. Drop ALU -> 4 load writes in order; q_empty after the last pop.
- WAW kill: queue holds a load rd=7 and alu write rd=7 occurs -> probe_addr=7 gives probe_hit=0; on pop, rf_w_en=0 for that cycle; no write of the stale load data.
- Same-cycle conflict and non-load: load rd=9 together with ALU rd=9 -> only the ALU write occurs and q_count is unchanged. Opcode 7'b0010000 with ld_valid_in=1 -> ignored.
- Reset mid-operation: 3 loads queued, rst=1 for one cycle -> all outputs 0, q_empty=1, probe_hit=0; no stale writes after reset deasserts.

Source files
------------

// File: rtl/ldr_writeback_queue.sv
// Writeback-stage load queue: decodes loads, buffers them in a DEPTH-entry FIFO and
// shares one register-file write port with the ALU path, which always wins.
module ldr_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid_in,
    input  logic [6:0]            opcode_in,
    input  logic [REG_ADDR_W-1:0] ld_rd_in,
    input  logic [DATA_W-1:0]     ld_data_in,
    input  logic                  alu_w_en_in,
    input  logic [REG_ADDR_W-1:0] alu_rd_in,
    input  logic [DATA_W-1:0]     alu_data_in,
    output logic                  rf_w_en,
    output logic [REG_ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0]     rf_w_data,
    output logic                  w_en_ldr,
    output logic                  ld_stall,
    output logic                  q_full,
    output logic                  q_empty,
    output logic [CNT_W-1:0]      q_count,
    input  logic [REG_ADDR_W-1:0] probe_addr,
    output logic                  probe_hit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [DEPTH-1:0]      live;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic is_load;
    logic accept;
    logic conflict;
    logic pop;
    logic bypass;
    logic push;

    // Handshake: ld_valid_in is a valid with no ready wire; ld_stall acts as !ready,
    // and a load offered while ld_stall is high is dropped, so upstream must hold it.
    assign is_load  = (opcode_in[6:4] == 3'b110) || (opcode_in[6:3] == 4'b1000);
    assign q_full   = (count == CNT_W'(DEPTH));
    assign q_empty  = (count == '0);
    assign ld_stall = q_full;
    assign q_count  = count;

    assign accept   = ld_valid_in && is_load && !q_full;
    // A load paired with an ALU write to the same rd is older and is discarded.
    assign conflict = alu_w_en_in && accept && (ld_rd_in == alu_rd_in);
    assign pop      = !alu_w_en_in && !q_empty;
    assign bypass   = !alu_w_en_in && q_empty && accept;
    assign push     = accept && !conflict && !bypass;

    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (rd_mem[i] == probe_addr)) probe_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= ld_rd_in;
            data_mem[wr_ptr] <= ld_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Kill first; a push into the free slot below overrides its cleared bit.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_w_en_in && (rd_mem[i] == alu_rd_in)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en   <= 1'b0;
            w_en_ldr  <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
        end else if (alu_w_en_in) begin
            rf_w_en   <= 1'b1;
            w_en_ldr  <= 1'b0;
            rf_w_addr <= alu_rd_in;
            rf_w_data <= alu_data_in;
        end else if (!q_empty) begin
            rf_w_en  <= live[rd_ptr];
            w_en_ldr <= live[rd_ptr];
            if (live[rd_ptr]) begin
                rf_w_addr <= rd_mem[rd_ptr];
                rf_w_data <= data_mem[rd_ptr];
            end
        end else if (accept) begin
            rf_w_en   <= 1'b1;
            w_en_ldr  <= 1'b1;
            rf_w_addr <= ld_rd_in;
            rf_w_data <= ld_data_in;
        end else begin
            rf_w_en  <= 1'b0;
            w_en_ldr <= 1'b0;
        end
    end

endmodule
